// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 4-digit scan controller: scan states,
// one-hot anode codes and the digit-index to display-field map.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_e;

    typedef enum logic [1:0] {
        FLD_OP   = 2'd0,
        FLD_ZERO = 2'd1,
        FLD_Y_LO = 2'd2,
        FLD_Y_HI = 2'd3
    } digit_field_e;

    localparam int          NUM_DIGITS = 4;
    localparam logic [1:0]  LAST_IDX   = 2'd3;

    localparam logic [3:0]  ANODE_OFF = 4'b0000;
    localparam logic [3:0]  ANODE_D0  = 4'b0001;
    localparam logic [3:0]  ANODE_D1  = 4'b0010;
    localparam logic [3:0]  ANODE_D2  = 4'b0100;
    localparam logic [3:0]  ANODE_D3  = 4'b1000;

    localparam digit_field_e FIELD_D0 = FLD_OP;
    localparam digit_field_e FIELD_D1 = FLD_ZERO;
    localparam digit_field_e FIELD_D2 = FLD_Y_LO;
    localparam digit_field_e FIELD_D3 = FLD_Y_HI;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = ANODE_D0;
            2'd1:    a = ANODE_D1;
            2'd2:    a = ANODE_D2;
            2'd3:    a = ANODE_D3;
            default: a = ANODE_OFF;
        endcase
        return a;
    endfunction

    function automatic digit_field_e field_for(input logic [1:0] idx);
        digit_field_e f;
        case (idx)
            2'd0:    f = FIELD_D0;
            2'd1:    f = FIELD_D1;
            2'd2:    f = FIELD_D2;
            2'd3:    f = FIELD_D3;
            default: f = FLD_ZERO;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] digit_for(input logic [1:0] idx,
                                             input logic [7:0] y_lo,
                                             input logic [3:0] op);
        logic [3:0] d;
        case (field_for(idx))
            FLD_OP:   d = op;
            FLD_ZERO: d = 4'h0;
            FLD_Y_LO: d = y_lo[3:0];
            FLD_Y_HI: d = y_lo[7:4];
            default:  d = 4'h0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_timer.sv
// Clearable up-counter with terminal-count compare; paces the lit and blank
// periods of the scan controller.
module seg_refresh_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    // Count up each cycle, restart from zero on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign tc = (cnt_r == tc_val);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit display scan controller: rotates a one-hot anode with dead-time
// between digits and commits new Y/OP data only at frame boundaries.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] Y,
    input  logic [3:0]  OP,
    input  logic        upd_valid,
    output logic        upd_ready,
    output logic [3:0]  anode,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam bit HAS_GAP = (BLANK_CYC > 0);
    localparam logic [CNT_W-1:0] SHOW_TC = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = HAS_GAP ? CNT_W'(BLANK_CYC - 1) : {CNT_W{1'b0}};

    scan_state_e      state_r, state_nxt_s;
    logic [1:0]       idx_r, idx_nxt_s;
    logic             clr_s, wrap_s, tc_s;
    logic [CNT_W-1:0] tc_val_s;

    logic             pend_r, upd_ready_r;
    logic [15:0]      pend_y_r, shadow_y_r, shadow_y_nxt_s;
    logic [3:0]       pend_op_r, shadow_op_r, shadow_op_nxt_s;
    logic             accept_s, commit_s;

    logic [3:0]       anode_r, digit_r, anode_nxt_s, digit_nxt_s;
    logic             frame_done_r;

    assign tc_val_s = (state_r == ST_GAP) ? GAP_TC : SHOW_TC;

    seg_refresh_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr_s),
        .tc_val (tc_val_s),
        .tc     (tc_s)
    );

    // Scan state and digit index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next scan state; any state change also restarts the period counter
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        clr_s       = 1'b0;
        wrap_s      = 1'b0;
        if (!enable) begin
            state_nxt_s = ST_OFF;
            idx_nxt_s   = 2'd0;
            clr_s       = 1'b1;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_nxt_s = ST_SHOW;
                    idx_nxt_s   = 2'd0;
                    clr_s       = 1'b1;
                end
                ST_SHOW: begin
                    if (tc_s) begin
                        clr_s = 1'b1;
                        if (HAS_GAP) begin
                            state_nxt_s = ST_GAP;
                        end else begin
                            idx_nxt_s = idx_r + 2'd1;
                            wrap_s    = (idx_r == LAST_IDX);
                        end
                    end else begin
                        state_nxt_s = ST_SHOW;
                    end
                end
                ST_GAP: begin
                    if (tc_s) begin
                        clr_s       = 1'b1;
                        state_nxt_s = ST_SHOW;
                        idx_nxt_s   = idx_r + 2'd1;
                        wrap_s      = (idx_r == LAST_IDX);
                    end else begin
                        state_nxt_s = ST_GAP;
                    end
                end
                default: begin
                    state_nxt_s = ST_OFF;
                    idx_nxt_s   = 2'd0;
                    clr_s       = 1'b1;
                end
            endcase
        end
    end

    // Load handshake: commit at the frame wrap, or straight away while off
    always_comb begin
        accept_s = upd_valid & upd_ready_r;
        commit_s = pend_r & (wrap_s | (state_r == ST_OFF));
        if (commit_s) begin
            shadow_y_nxt_s  = pend_y_r;
            shadow_op_nxt_s = pend_op_r;
        end else begin
            shadow_y_nxt_s  = shadow_y_r;
            shadow_op_nxt_s = shadow_op_r;
        end
    end

    // Pending slot and displayed shadow copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r      <= 1'b0;
            pend_y_r    <= 16'h0000;
            pend_op_r   <= 4'h0;
            upd_ready_r <= 1'b1;
            shadow_y_r  <= 16'h0000;
            shadow_op_r <= 4'h0;
        end else begin
            if (accept_s) begin
                pend_r      <= 1'b1;
                pend_y_r    <= Y;
                pend_op_r   <= OP;
                upd_ready_r <= 1'b0;
            end else if (commit_s) begin
                pend_r      <= 1'b0;
                upd_ready_r <= 1'b1;
            end
            shadow_y_r  <= shadow_y_nxt_s;
            shadow_op_r <= shadow_op_nxt_s;
        end
    end

    // Output decode from the next state so anode/digit move with the state register
    always_comb begin
        anode_nxt_s = ANODE_OFF;
        digit_nxt_s = digit_r;
        if (state_nxt_s == ST_SHOW) begin
            anode_nxt_s = anode_for(idx_nxt_s);
            digit_nxt_s = digit_for(idx_nxt_s, shadow_y_nxt_s[7:0], shadow_op_nxt_s);
        end else begin
            anode_nxt_s = ANODE_OFF;
            digit_nxt_s = digit_r;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_r      <= ANODE_OFF;
            digit_r      <= 4'h0;
            frame_done_r <= 1'b0;
        end else begin
            anode_r      <= anode_nxt_s;
            digit_r      <= digit_nxt_s;
            frame_done_r <= wrap_s;
        end
    end

    assign anode      = anode_r;
    assign digit      = digit_r;
    assign frame_done = frame_done_r;
    assign upd_ready  = upd_ready_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (REFRESH_DIV=4, BLANK_CYC=1)
// against a time-position model of the scan schedule.
module tb_seven_seg_scan_ctrl;

    localparam int RDIV  = 4;
    localparam int BLANK = 1;
    localparam int SLOT  = RDIV + BLANK;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n, enable, upd_valid;
    logic [15:0] Y;
    logic [3:0]  OP;
    logic        upd_ready, frame_done;
    logic [3:0]  anode, digit;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_scan, m_pend, m_ready, m_fd, m_acc;
    int          m_t;
    logic [15:0] m_y, m_py;
    logic [3:0]  m_op, m_pop, m_anode, m_digit;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  op;
    } load_t;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.REFRESH_DIV(RDIV), .BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .Y          (Y),
        .OP         (OP),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .anode      (anode),
        .digit      (digit),
        .frame_done (frame_done)
    );

    task automatic model_reset();
        m_scan = 0; m_pend = 0; m_ready = 1; m_fd = 0; m_acc = 0; m_t = 0;
        m_y = 16'h0; m_py = 16'h0; m_op = 4'h0; m_pop = 4'h0;
        m_anode = 4'h0; m_digit = 4'h0;
    endtask

    // One clock: model the position in the frame from cycles spent scanning
    task automatic tick();
        bit prev_scan;
        int p, slot;
        @(posedge clk);
        prev_scan = m_scan;
        m_acc = upd_valid && m_ready;
        if (enable) begin
            m_t    = prev_scan ? m_t + 1 : 0;
            m_scan = 1;
        end else begin
            m_t    = 0;
            m_scan = 0;
        end
        p    = m_t % FRAME;
        slot = p / SLOT;
        m_fd = m_scan && (m_t > 0) && (p == 0);
        if (m_pend && (m_fd || !prev_scan)) begin
            m_y = m_py; m_op = m_pop; m_pend = 0;
        end else if (m_acc) begin
            m_py = Y; m_pop = OP; m_pend = 1;
        end
        m_ready = !m_pend;
        if (m_scan && (p % SLOT) < RDIV) begin
            m_anode = 4'b0001 << slot;
            case (slot)
                0:       m_digit = m_op;
                1:       m_digit = 4'h0;
                2:       m_digit = m_y[3:0];
                default: m_digit = m_y[7:4];
            endcase
        end else begin
            m_anode = 4'h0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; upd_valid = 1'b0; Y = 16'h0; OP = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({anode, digit, frame_done, upd_ready} !== {4'h0, 4'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got anode=%b digit=%h fd=%b rdy=%b, expected 0000 0 0 1",
                     anode, digit, frame_done, upd_ready);
        end
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            n_checks++;
            if ({anode, digit, frame_done, upd_ready} !== {m_anode, m_digit, m_fd, m_ready}) begin
                n_fail++;
                $display("FAIL idle_after_reset: got %b/%h/%b/%b expected %b/%h/%b/%b",
                         anode, digit, frame_done, upd_ready, m_anode, m_digit, m_fd, m_ready);
            end
        end
    endtask

    task automatic test_scan();
        int pulses = 0, first = -1, last = -1;
        enable = 1'b1;
        for (int c = 0; c < 45; c++) begin
            tick();
            n_checks++;
            if ({anode, digit, frame_done, upd_ready} !== {m_anode, m_digit, m_fd, m_ready}) begin
                n_fail++;
                $display("FAIL scan: cyc %0d got %b/%h/%b/%b expected %b/%h/%b/%b", c,
                         anode, digit, frame_done, upd_ready, m_anode, m_digit, m_fd, m_ready);
            end
            if (frame_done) begin
                pulses++;
                if (first < 0) first = c;
                last = c;
            end
        end
        n_checks++;
        if (pulses !== 2 || (last - first) !== FRAME) begin
            n_fail++;
            $display("FAIL frame_period: got %0d pulses spaced %0d, expected 2 spaced %0d",
                     pulses, last - first, FRAME);
        end
    endtask

    task automatic test_load();
        bit seen = 0;
        repeat ($urandom_range(3, 12)) begin
            tick();
            n_checks++;
            if ({anode, digit, frame_done, upd_ready} !== {m_anode, m_digit, m_fd, m_ready}) begin
                n_fail++;
                $display("FAIL load_pre: got %b/%h/%b/%b expected %b/%h/%b/%b",
                         anode, digit, frame_done, upd_ready, m_anode, m_digit, m_fd, m_ready);
            end
        end
        upd_valid = 1'b1; Y = 16'h00A5; OP = 4'h3;
        tick();
        upd_valid = 1'b0; Y = 16'($urandom); OP = 4'($urandom);
        for (int c = 0; c < 70; c++) begin
            n_checks++;
            if ({anode, digit, frame_done, upd_ready} !== {m_anode, m_digit, m_fd, m_ready}) begin
                n_fail++;
                $display("FAIL load: cyc %0d got %b/%h/%b/%b expected %b/%h/%b/%b", c,
                         anode, digit, frame_done, upd_ready, m_anode, m_digit, m_fd, m_ready);
            end
            if (frame_done && !seen) begin
                seen = 1;
                n_checks++;
                if ({anode, digit} !== {4'b0001, 4'h3}) begin
                    n_fail++;
                    $display("FAIL load_commit: got anode=%b digit=%h, expected 0001 3", anode, digit);
                end
            end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL load_timeout: got no frame_done, expected one within 70 cycles");
        end
    endtask

    task automatic test_back_to_back();
        load_t q[$];
        int after = 0, budget = 0;
        q.push_back('{16'h0012, 4'($urandom)});
        q.push_back('{16'h0034, 4'($urandom)});
        q.push_back('{16'($urandom), 4'($urandom)});
        while (after < 2 * FRAME && budget < 400) begin
            if (q.size() > 0) begin
                upd_valid = 1'b1; Y = q[0].y; OP = q[0].op;
            end else begin
                upd_valid = 1'b0; after++;
            end
            tick();
            budget++;
            if (m_acc) void'(q.pop_front());
            n_checks++;
            if ({anode, digit, frame_done, upd_ready} !== {m_anode, m_digit, m_fd, m_ready}) begin
                n_fail++;
                $display("FAIL back_to_back: cyc %0d got %b/%h/%b/%b expected %b/%h/%b/%b", budget,
                         anode, digit, frame_done, upd_ready, m_anode, m_digit, m_fd, m_ready);
            end
        end
        upd_valid = 1'b0;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d loads unaccepted, expected 0", q.size());
        end
    endtask

    task automatic test_enable_drop();
        for (int it = 0; it < 3; it++) begin
            int target = (it == 0) ? (2 * SLOT + RDIV) : $urandom_range(0, FRAME - 1);
            int lit0 = 0, guard = 0;
            while (!(m_scan && (m_t % FRAME) == target) && guard < 2 * FRAME) begin
                tick(); guard++;
            end
            n_checks++;
            if (guard >= 2 * FRAME) begin
                n_fail++;
                $display("FAIL drop_seek: got no frame position %0d, expected it within %0d", target, 2 * FRAME);
            end
            enable = 1'b0;
            repeat ($urandom_range(1, 4)) begin
                tick();
                n_checks++;
                if ({anode, digit, frame_done, upd_ready} !== {m_anode, m_digit, m_fd, m_ready}) begin
                    n_fail++;
                    $display("FAIL drop_off: got %b/%h/%b/%b expected %b/%h/%b/%b",
                             anode, digit, frame_done, upd_ready, m_anode, m_digit, m_fd, m_ready);
                end
            end
            enable = 1'b1;
            for (int c = 0; c < FRAME + 5; c++) begin
                tick();
                if (c < SLOT && anode == 4'b0001) lit0++;
                n_checks++;
                if ({anode, digit, frame_done, upd_ready} !== {m_anode, m_digit, m_fd, m_ready}) begin
                    n_fail++;
                    $display("FAIL drop_resume: cyc %0d got %b/%h/%b/%b expected %b/%h/%b/%b", c,
                             anode, digit, frame_done, upd_ready, m_anode, m_digit, m_fd, m_ready);
                end
            end
            n_checks++;
            if (lit0 !== RDIV) begin
                n_fail++;
                $display("FAIL resume_idx0: got %0d lit cycles, expected %0d", lit0, RDIV);
            end
        end
    endtask

    task automatic test_load_disabled();
        logic [3:0] op_v;
        op_v = 4'($urandom);
        enable = 1'b0;
        tick();
        upd_valid = 1'b1; Y = 16'($urandom); OP = op_v;
        for (int c = 0; c < 5; c++) begin
            tick();
            upd_valid = 1'b0;
            n_checks++;
            if ({anode, digit, frame_done, upd_ready} !== {m_anode, m_digit, m_fd, m_ready}) begin
                n_fail++;
                $display("FAIL load_off: cyc %0d got %b/%h/%b/%b expected %b/%h/%b/%b", c,
                         anode, digit, frame_done, upd_ready, m_anode, m_digit, m_fd, m_ready);
            end
        end
        enable = 1'b1;
        tick();
        n_checks++;
        if ({anode, digit} !== {4'b0001, op_v}) begin
            n_fail++;
            $display("FAIL load_off_shown: got anode=%b digit=%h, expected 0001 %h", anode, digit, op_v);
        end
        for (int c = 0; c < FRAME + 3; c++) begin
            tick();
            n_checks++;
            if ({anode, digit, frame_done, upd_ready} !== {m_anode, m_digit, m_fd, m_ready}) begin
                n_fail++;
                $display("FAIL load_off_scan: cyc %0d got %b/%h/%b/%b expected %b/%h/%b/%b", c,
                         anode, digit, frame_done, upd_ready, m_anode, m_digit, m_fd, m_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        repeat ($urandom_range(2, 9)) tick();
        upd_valid = 1'b1; Y = 16'($urandom) | 16'h0001; OP = 4'($urandom) | 4'h1;
        tick();
        upd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({anode, digit, frame_done, upd_ready} !== {4'h0, 4'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: got anode=%b digit=%h fd=%b rdy=%b, expected 0000 0 0 1",
                     anode, digit, frame_done, upd_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < FRAME + 5; c++) begin
            tick();
            n_checks++;
            if ({anode, digit, frame_done, upd_ready} !== {m_anode, m_digit, m_fd, m_ready}) begin
                n_fail++;
                $display("FAIL reset_mid_scan: cyc %0d got %b/%h/%b/%b expected %b/%h/%b/%b", c,
                         anode, digit, frame_done, upd_ready, m_anode, m_digit, m_fd, m_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_enable_drop();
        test_load_disabled();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
